// File: rtl/sipo_deser_if.sv
// rtl/sipo_deser_if.sv - serial input and word output bundle for the SIPO deserializer
interface sipo_deser_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             start;
  logic             d;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;

  // Producer of the serial stream and consumer of assembled words
  modport master (
    output en,
    output start,
    output d,
    output out_ready,
    input  out,
    input  out_valid
  );

  // Deserializer side
  modport slave (
    input  en,
    input  start,
    input  d,
    input  out_ready,
    output out,
    output out_valid
  );
endinterface

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-to-parallel deserializer with start-of-frame marker and overrun flag
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr_ovr,
  output logic          o_busy,
  output logic          o_overrun,
  sipo_deser_if.slave   s_bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_overrun;
  logic             w_capture;
  logic             w_restart;
  logic             w_complete;
  logic             w_accept;
  logic             w_drop;

  // Next-state decode: decide whether this edge samples d, and whether that sample opens or closes a frame
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_capture   = 1'b0;
    w_restart   = 1'b0;
    w_complete  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (s_bus.en && s_bus.start) begin
          w_capture = 1'b1;
          w_restart = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (s_bus.en) begin
          w_capture = 1'b1;
          w_restart = s_bus.start;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_capture) begin
      // A restart throws away partial bits so no residue of the old frame can leak into the word
      if (w_restart) begin
        w_cnt_nxt = ONE_CNT;
        if (MSB_FIRST) w_shift_nxt = {{(WIDTH-1){1'b0}}, s_bus.d};
        else           w_shift_nxt = {s_bus.d, {(WIDTH-1){1'b0}}};
      end else begin
        w_cnt_nxt = r_cnt + ONE_CNT;
        if (MSB_FIRST) w_shift_nxt = {r_shift[WIDTH-2:0], s_bus.d};
        else           w_shift_nxt = {s_bus.d, r_shift[WIDTH-1:1]};
      end

      if (w_cnt_nxt == LAST_CNT) begin
        w_complete  = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end else begin
        w_state_nxt = ST_SHIFT;
      end
    end
  end

  // A completed word is taken if the output slot is empty or being drained this same edge
  assign w_accept = w_complete && (!r_out_valid || s_bus.out_ready);
  assign w_drop   = w_complete && r_out_valid && !s_bus.out_ready;

  // Frame state register: state, bit count, shift register and busy flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_busy  <= (w_state_nxt == ST_SHIFT);
    end
  end

  // Output stage: load on accepted completion, otherwise retire the word when the consumer takes it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out       <= w_shift_nxt;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && s_bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky overrun: a dropped word beats a simultaneous clear
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (i_clr_ovr) begin
      r_overrun <= 1'b0;
    end
  end

  assign s_bus.out       = r_out;
  assign s_bus.out_valid = r_out_valid;
  assign o_busy          = r_busy;
  assign o_overrun       = r_overrun;

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - table vectors, random stream against a frame-level model, async reset abort
module tb_sipo_deser;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_ovr = 1'b0;
  logic busy_m, ovr_m, busy_l, ovr_l;

  int checks = 0;
  int errors = 0;

  sipo_deser_if #(.WIDTH(W)) bus_m ();
  sipo_deser_if #(.WIDTH(W)) bus_l ();

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_clr_ovr (clr_ovr),
    .o_busy    (busy_m),
    .o_overrun (ovr_m),
    .s_bus     (bus_m.slave)
  );

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_clr_ovr (clr_ovr),
    .o_busy    (busy_l),
    .o_overrun (ovr_l),
    .s_bus     (bus_l.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, st, d, rdy, clr;
    logic [3:0] x_msb, x_lsb;
    logic       x_vld, x_busy, x_ovr;
  } vec_t;

  vec_t tbl[$];

  // Frame-level reference: bits of the frame in progress, plus the output slot
  logic       m_bits[$];
  logic [3:0] m_msb, m_lsb;
  logic       m_vld, m_ovr;

  task automatic add(input logic en, st, d, rdy, clr,
                     input logic [3:0] xm, xl, input logic xv, xb, xo);
    vec_t v;
    v.en = en; v.st = st; v.d = d; v.rdy = rdy; v.clr = clr;
    v.x_msb = xm; v.x_lsb = xl; v.x_vld = xv; v.x_busy = xb; v.x_ovr = xo;
    tbl.push_back(v);
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_msb = '0; m_lsb = '0; m_vld = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_step(input logic en, st, d, rdy, clr);
    logic       done, dropped;
    logic [3:0] wm, wl;
    done = 1'b0; dropped = 1'b0; wm = '0; wl = '0;
    if (en) begin
      if (st) begin
        m_bits.delete();
        m_bits.push_back(d);
      end else if (m_bits.size() != 0) begin
        m_bits.push_back(d);
      end
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = m_bits[i];
          wl[i]     = m_bits[i];
        end
        done = 1'b1;
        m_bits.delete();
      end
    end
    if (done) begin
      if (!m_vld || rdy) begin
        m_vld = 1'b1; m_msb = wm; m_lsb = wl;
      end else begin
        dropped = 1'b1;
      end
    end else if (m_vld && rdy) begin
      m_vld = 1'b0;
    end
    if (dropped) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] xm, xl, input logic xv, xb, xo);
    chk({tag, " msb.out"},   32'(bus_m.out),       32'(xm));
    chk({tag, " lsb.out"},   32'(bus_l.out),       32'(xl));
    chk({tag, " msb.valid"}, 32'(bus_m.out_valid), 32'(xv));
    chk({tag, " lsb.valid"}, 32'(bus_l.out_valid), 32'(xv));
    chk({tag, " msb.busy"},  32'(busy_m),          32'(xb));
    chk({tag, " lsb.busy"},  32'(busy_l),          32'(xb));
    chk({tag, " msb.ovr"},   32'(ovr_m),           32'(xo));
    chk({tag, " lsb.ovr"},   32'(ovr_l),           32'(xo));
  endtask

  // Drive at the falling edge, let one rising edge act, then return at the next falling edge
  task automatic drive(input logic en, st, d, rdy, clr);
    bus_m.en = en; bus_m.start = st; bus_m.d = d; bus_m.out_ready = rdy;
    bus_l.en = en; bus_l.start = st; bus_l.d = d; bus_l.out_ready = rdy;
    clr_ovr = clr;
    @(posedge clk);
    model_step(en, st, d, rdy, clr);
    @(negedge clk);
  endtask

  initial begin
    bus_m.en = 0; bus_m.start = 0; bus_m.d = 0; bus_m.out_ready = 0;
    bus_l.en = 0; bus_l.start = 0; bus_l.d = 0; bus_l.out_ready = 0;
    model_reset();

    // basic frame 1010, one-cycle valid
    add(1,1,1,1,0, 4'h0,4'h0,0,1,0);
    add(1,0,0,1,0, 4'h0,4'h0,0,1,0);
    add(1,0,1,1,0, 4'h0,4'h0,0,1,0);
    add(1,0,0,1,0, 4'hA,4'h5,1,0,0);
    add(0,0,0,1,0, 4'hA,4'h5,0,0,0);
    // 1101 with en gaps, start ignored while en=0
    add(1,1,1,1,0, 4'hA,4'h5,0,1,0);
    add(0,0,0,1,0, 4'hA,4'h5,0,1,0);
    add(1,0,1,1,0, 4'hA,4'h5,0,1,0);
    add(0,1,0,1,0, 4'hA,4'h5,0,1,0);
    add(0,0,1,1,0, 4'hA,4'h5,0,1,0);
    add(1,0,0,1,0, 4'hA,4'h5,0,1,0);
    add(1,0,1,1,0, 4'hD,4'hB,1,0,0);
    // stalled consumer: 1010 held, 0110 dropped, then drain and clear
    add(0,0,0,1,0, 4'hD,4'hB,0,0,0);
    add(1,1,1,0,0, 4'hD,4'hB,0,1,0);
    add(1,0,0,0,0, 4'hD,4'hB,0,1,0);
    add(1,0,1,0,0, 4'hD,4'hB,0,1,0);
    add(1,0,0,0,0, 4'hA,4'h5,1,0,0);
    add(1,1,0,0,0, 4'hA,4'h5,1,1,0);
    add(1,0,1,0,0, 4'hA,4'h5,1,1,0);
    add(1,0,1,0,0, 4'hA,4'h5,1,1,0);
    add(1,0,0,0,0, 4'hA,4'h5,1,0,1);
    add(0,0,0,1,0, 4'hA,4'h5,0,0,1);
    add(0,0,0,0,1, 4'hA,4'h5,0,0,0);
    // drop and clear on the same edge: set wins
    add(1,1,1,0,0, 4'hA,4'h5,0,1,0);
    add(1,0,1,0,0, 4'hA,4'h5,0,1,0);
    add(1,0,1,0,0, 4'hA,4'h5,0,1,0);
    add(1,0,1,0,0, 4'hF,4'hF,1,0,0);
    add(1,1,0,0,1, 4'hF,4'hF,1,1,0);
    add(1,0,0,0,0, 4'hF,4'hF,1,1,0);
    add(1,0,0,0,0, 4'hF,4'hF,1,1,0);
    add(1,0,0,0,1, 4'hF,4'hF,1,0,1);
    add(0,0,0,1,0, 4'hF,4'hF,0,0,1);
    add(0,0,0,0,1, 4'hF,4'hF,0,0,0);
    // restart mid-frame: 1,1 discarded, word 0011
    add(1,1,1,1,0, 4'hF,4'hF,0,1,0);
    add(1,0,1,1,0, 4'hF,4'hF,0,1,0);
    add(1,1,0,1,0, 4'hF,4'hF,0,1,0);
    add(1,0,0,1,0, 4'hF,4'hF,0,1,0);
    add(1,0,1,1,0, 4'hF,4'hF,0,1,0);
    add(1,0,1,1,0, 4'h3,4'hC,1,0,0);
    // next frame starts the cycle after completion; 1000 vs 0001 bit order
    add(1,1,1,1,0, 4'h3,4'hC,0,1,0);
    add(1,0,0,1,0, 4'h3,4'hC,0,1,0);
    add(1,0,0,1,0, 4'h3,4'hC,0,1,0);
    add(1,0,0,1,0, 4'h8,4'h1,1,0,0);
    // completion while valid and ready: replaced back-to-back, no overrun
    add(1,1,0,0,0, 4'h8,4'h1,1,1,0);
    add(1,0,1,0,0, 4'h8,4'h1,1,1,0);
    add(1,0,1,0,0, 4'h8,4'h1,1,1,0);
    add(1,0,1,1,0, 4'h7,4'hE,1,0,0);
    add(0,0,0,1,0, 4'h7,4'hE,0,0,0);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all("reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].st, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      check_all($sformatf("vec%0d", i), tbl[i].x_msb, tbl[i].x_lsb,
                tbl[i].x_vld, tbl[i].x_busy, tbl[i].x_ovr);
    end

    for (int i = 0; i < 600; i++) begin
      logic en, st, d, rdy, clr;
      en  = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 7) == 0);
      d   = 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 15) == 0);
      drive(en, st, d, rdy, clr);
      check_all($sformatf("rnd%0d", i), m_msb, m_lsb, m_vld,
                (m_bits.size() != 0), m_ovr);
    end

    // asynchronous reset two bits into a frame
    drive(0,0,0,1,1);
    drive(1,1,1,1,0);
    drive(1,0,0,1,0);
    chk("abort pre-reset busy", 32'(busy_m), 32'(1));
    #2 rst = 1'b1;
    #1;
    check_all("async rst", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(1,1,1,1,0);
    drive(1,0,1,1,0);
    drive(1,0,1,1,0);
    drive(1,0,1,1,0);
    check_all("post-abort", 4'hF, 4'hF, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
